pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). Detects load-use hazards, squashes wrong-path instructions after a taken branch, freezes the pipe while data memory is busy, and drains then halts the pipe on HLT. Drives the stall/bubble/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, where stall holds the register contents and bubble/flush loads all-zero controls (a NOP).

Parameters:
MEM_TIMEOUT, 64, maximum consecutive data-memory wait cycles before mem_err is raised
DRAIN_CYCLES, 3, cycles needed after HLT leaves ID for older instructions to retire (EX, MEM, WB)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
src0_ID  in  4  rs register index of instruction in ID
src1_ID  in  4  rt register index of instruction in ID
src0_used_ID  in  1  ID instruction reads src0
src1_used_ID  in  1  ID instruction reads src1
hlt_ID  in  1  instruction in ID is HLT
dst_EX  in  4  destination register of instruction in EX
re_mem_EX  in  1  instruction in EX is a load
branch_taken_EX  in  1  branch/jump in EX resolved taken
mem_req_MEM  in  1  MEM stage access in progress
mem_rdy_MEM  in  1  data memory completes access this cycle
stall_IF  out  1  hold PC and IF/ID register
stall_ID  out  1  hold ID/EX register
stall_EX  out  1  hold EX/MEM register
stall_MEM  out  1  hold MEM/WB register
flush_ID  out  1  load NOP into IF/ID
bubble_EX  out  1  load NOP controls into ID/EX
halted  out  1  pipe fully drained and stopped
mem_err  out  1  sticky: memory timeout occurred
stall_cnt  out  CNT_W  saturating count of cycles with stall_IF high

Behaviour:
- Clock clk, reset rst asynchronous active-high. While rst=1: state=RUN, all counters 0, mem_err=0, and all outputs forced 0.
- States: RUN, MEM_WAIT, DRAIN, HALTED. Registered: state, wait_cnt, drain_cnt, mem_err, stall_cnt. Stall/flush outputs combinational from state and inputs (zero-cycle latency).
- mem_busy = mem_req_MEM & ~mem_rdy_MEM.
- load_use = re_mem_EX & dst_EX!=0 & ((src0_used_ID & src0_ID==dst_EX) | (src1_used_ID & src1_ID==dst_EX)); R0 never hazards.
- Priority in RUN, highest first:
  1. mem_busy: stall_IF=stall_ID=stall_EX=stall_MEM=1; no flush/bubble; next state MEM_WAIT, wait_cnt<=1.
  2. branch_taken_EX: flush_ID=1, bubble_EX=1, no stall; hlt_ID and load_use ignored (wrong path).
  3. load_use: stall_IF=1, bubble_EX=1 for exactly one cycle. The load advances to MEM, so the hazard clears by itself. hlt_ID is not acted on this cycle.
  4. hlt_ID: HLT enters EX normally; stall_IF=1 from this cycle on; next state DRAIN, drain_cnt<=0.
- MEM_WAIT: all four stalls held while mem_busy. wait_cnt increments and saturates. When mem_rdy_MEM=1: stalls drop that cycle and state returns to RUN; branch/load_use are evaluated that cycle as in RUN. If wait_cnt reaches MEM_TIMEOUT with mem_busy still high: set mem_err, go to HALTED.
- DRAIN: stall_IF=1, flush_ID=1, bubble_EX=1 every cycle. A mem_busy in DRAIN also holds EX/MEM and MEM/WB, and drain_cnt does not advance. drain_cnt increments otherwise. At drain_cnt==DRAIN_CYCLES-1, go to HALTED.
- HALTED: halted=1, all four stalls=1, bubble/flush=0. Only rst exits. mem_err remains sticky until rst.
- stall_cnt increments each cycle stall_IF=1 in RUN, MEM_WAIT or DRAIN. It does not count in HALTED and saturates at all-ones.
- branch_taken_EX during MEM_WAIT is ignored: EX is held and re-evaluated after release.
- Reset mid-MEM_WAIT or mid-DRAIN: immediate return to RUN with counters cleared.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum (RUN, MEM_WAIT, DRAIN, HALTED), register-index width constant (4), NOP control encoding used by bubble/flush.
- One sub-module: sat_counter (parameterised width, inc, clr, saturates), instanced for wait_cnt and stall_cnt.

Test Plan:
- Load-use: EX = LW R3 (re_mem_EX=1, dst_EX=3), ID = ADD reading src1_ID=3 -> one cycle of stall_IF=1, bubble_EX=1, then deasserted; stall_cnt=1.
- R0 load: dst_EX=0 with matching src0_ID=0 -> no stall, no bubble.
- Taken branch with simultaneous load_use and hlt_ID -> flush_ID=1, bubble_EX=1, stall_IF=0; state stays RUN.
- Memory wait: mem_req_MEM=1, mem_rdy_MEM low for 5 cycles then high -> all stalls high for 5 cycles, low on the rdy cycle; stall_cnt=5; mem_err=0.
- Timeout: mem_rdy_MEM never asserted -> mem_err=1 and halted=1 after MEM_TIMEOUT cycles; rst clears both.
- HLT: hlt_ID=1 in RUN with no hazards -> 3 DRAIN cycles with stall_IF=1, then halted=1 and all stalls high; asserting rst mid-DRAIN returns to RUN with outputs 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
    localparam int REG_W = 4;
    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic bubble_ex;
    } hz_ctrl_t;
    localparam hz_ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign q = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, branch, memory wait and HLT drain
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src0_ID,
    input  logic [REG_W-1:0] src1_ID,
    input  logic             src0_used_ID,
    input  logic             src1_used_ID,
    input  logic             hlt_ID,
    input  logic [REG_W-1:0] dst_EX,
    input  logic             re_mem_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_rdy_MEM,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             flush_ID,
    output logic             bubble_EX,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

    state_t          state_q, state_d;
    logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic [WC_W-1:0] wait_cnt;
    logic            wait_inc, stall_inc;
    logic            mem_busy, load_use;
    hz_ctrl_t        ctrl;

    assign mem_busy = mem_req_MEM & ~mem_rdy_MEM;
    assign load_use = re_mem_EX && dst_EX != '0 &&
                      ((src0_used_ID && src0_ID == dst_EX) || (src1_used_ID && src1_ID == dst_EX));

    always_comb begin
        ctrl        = CTRL_NOP;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        mem_err_d   = mem_err_q;
        wait_inc    = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    ctrl.stall_if  = 1'b1;
                    ctrl.stall_id  = 1'b1;
                    ctrl.stall_ex  = 1'b1;
                    ctrl.stall_mem = 1'b1;
                    wait_inc       = 1'b1;
                    state_d        = MEM_WAIT;
                    if (state_q == MEM_WAIT && wait_cnt >= WC_W'(MEM_TIMEOUT)) begin
                        mem_err_d = 1'b1;
                        state_d   = HALTED;
                    end
                end else begin
                    state_d = RUN;
                    if (branch_taken_EX) begin
                        ctrl.flush_id  = 1'b1;
                        ctrl.bubble_ex = 1'b1;
                    end else if (load_use) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.bubble_ex = 1'b1;
                    end else if (hlt_ID) begin
                        ctrl.stall_if = 1'b1;
                        state_d       = DRAIN;
                        drain_cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                ctrl.stall_if  = 1'b1;
                ctrl.flush_id  = 1'b1;
                ctrl.bubble_ex = 1'b1;
                if (mem_busy) begin
                    ctrl.stall_ex  = 1'b1;
                    ctrl.stall_mem = 1'b1;
                end else if (drain_cnt_q == DC_W'(DRAIN_CYCLES - 1)) begin
                    state_d = HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            HALTED: begin
                ctrl.stall_if  = 1'b1;
                ctrl.stall_id  = 1'b1;
                ctrl.stall_ex  = 1'b1;
                ctrl.stall_mem = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            mem_err_q   <= mem_err_d;
        end

    // wait_cnt idles at zero so the first busy cycle in RUN leaves it at one
    sat_counter #(.W(WC_W)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~wait_inc),
        .inc (wait_inc),
        .q   (wait_cnt)
    );

    assign stall_inc = ctrl.stall_if && state_q != HALTED;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    assign stall_IF  = ~rst & ctrl.stall_if;
    assign stall_ID  = ~rst & ctrl.stall_id;
    assign stall_EX  = ~rst & ctrl.stall_ex;
    assign stall_MEM = ~rst & ctrl.stall_mem;
    assign flush_ID  = ~rst & ctrl.flush_id;
    assign bubble_EX = ~rst & ctrl.bubble_ex;
    assign halted    = ~rst & (state_q == HALTED);
    assign mem_err   = mem_err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src0_ID, src1_ID, dst_EX;
    logic        src0_used_ID, src1_used_ID, hlt_ID, re_mem_EX, branch_taken_EX;
    logic        mem_req_MEM, mem_rdy_MEM;
    logic        stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, bubble_EX, halted, mem_err;
    logic [15:0] stall_cnt;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cycles;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .src0_ID         (src0_ID),
        .src1_ID         (src1_ID),
        .src0_used_ID    (src0_used_ID),
        .src1_used_ID    (src1_used_ID),
        .hlt_ID          (hlt_ID),
        .dst_EX          (dst_EX),
        .re_mem_EX       (re_mem_EX),
        .branch_taken_EX (branch_taken_EX),
        .mem_req_MEM     (mem_req_MEM),
        .mem_rdy_MEM     (mem_rdy_MEM),
        .stall_IF        (stall_IF),
        .stall_ID        (stall_ID),
        .stall_EX        (stall_EX),
        .stall_MEM       (stall_MEM),
        .flush_ID        (flush_ID),
        .bubble_EX       (bubble_EX),
        .halted          (halted),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    wire [3:0] stalls = {stall_IF, stall_ID, stall_EX, stall_MEM};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        src0_ID = 0; src1_ID = 0; dst_EX = 0;
        src0_used_ID = 0; src1_used_ID = 0; hlt_ID = 0;
        re_mem_EX = 0; branch_taken_EX = 0; mem_req_MEM = 0; mem_rdy_MEM = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic set_load_use();
        re_mem_EX = 1; dst_EX = 3; src1_ID = 3; src1_used_ID = 1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        mem_req_MEM = 1; hlt_ID = 1;
        @(negedge clk);
        chk("rst_stalls", stalls, 4'h0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_err", mem_err, 0);
        idle();
        step();
        rst = 1'b0;
        step();

        set_load_use();
        @(negedge clk);
        chk("lu_stall_if", stall_IF, 1);
        chk("lu_bubble", bubble_EX, 1);
        chk("lu_other", {stall_ID, stall_EX, stall_MEM, flush_ID}, 4'h0);
        step();
        re_mem_EX = 0;
        @(negedge clk);
        chk("lu_clear", {stall_IF, bubble_EX}, 2'b00);
        chk("lu_cnt", stall_cnt, 1);

        step();
        idle();
        re_mem_EX = 1; dst_EX = 0; src0_ID = 0; src0_used_ID = 1;
        @(negedge clk);
        chk("r0_no_hazard", {stall_IF, bubble_EX}, 2'b00);

        step();
        idle();
        set_load_use();
        hlt_ID = 1; branch_taken_EX = 1;
        @(negedge clk);
        chk("br_flush_bubble", {flush_ID, bubble_EX}, 2'b11);
        chk("br_no_stall", stall_IF, 0);
        step();
        idle();
        @(negedge clk);
        chk("br_stays_run", {stall_IF, halted}, 2'b00);

        step();
        do_reset();
        mem_req_MEM = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("mw_stall%0d", i), stalls, 4'hf);
            chk($sformatf("mw_noflush%0d", i), {flush_ID, bubble_EX}, 2'b00);
            step();
        end
        mem_rdy_MEM = 1;
        @(negedge clk);
        chk("mw_release", stalls, 4'h0);
        step();
        idle();
        @(negedge clk);
        chk("mw_cnt", stall_cnt, 5);
        chk("mw_err", mem_err, 0);
        chk("mw_run", {stalls, halted}, 5'h0);

        step();
        do_reset();
        mem_req_MEM = 1;
        cycles = 0;
        while (!halted && cycles < 200) begin
            step();
            cycles++;
            @(negedge clk);
            if (cycles == 10) chk("to_early_err", mem_err, 0);
        end
        chk("to_halted", halted, 1);
        chk("to_err", mem_err, 1);
        chk("to_not_early", cycles >= 64, 1);
        chk("to_halt_stalls", stalls, 4'hf);
        mem_req_MEM = 0;
        step();
        @(negedge clk);
        chk("to_sticky", {halted, mem_err}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("to_rst_clear", {halted, mem_err}, 2'b00);
        step();
        rst = 1'b0;
        idle();

        step();
        hlt_ID = 1;
        @(negedge clk);
        chk("hlt_stall_if", stall_IF, 1);
        chk("hlt_enters_ex", {stall_ID, flush_ID, bubble_EX}, 3'b000);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d", i), {stall_IF, flush_ID, bubble_EX, halted}, 4'b1110);
            step();
        end
        @(negedge clk);
        chk("hlt_halted", halted, 1);
        chk("hlt_stalls", stalls, 4'hf);
        chk("hlt_noflush", {flush_ID, bubble_EX}, 2'b00);
        chk("hlt_cnt", stall_cnt, 4);
        step();
        @(negedge clk);
        chk("hlt_cnt_frozen", stall_cnt, 4);

        do_reset();
        hlt_ID = 1;
        step();
        idle();
        mem_req_MEM = 1;
        @(negedge clk);
        chk("drain_mem_hold", stalls, 4'b1011);
        step();
        step();
        step();
        @(negedge clk);
        chk("drain_mem_no_adv", halted, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("drain_rst_out", {stalls, flush_ID, bubble_EX, halted, stall_cnt}, 23'h0);
        idle();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("drain_rst_run", {stall_IF, flush_ID, bubble_EX, halted}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
